// File: rtl/bresenham_pkg.sv
// Shared definitions for the Bresenham line engine: default coordinate
// width, FSM state encoding and the signed error-accumulator type.
package bresenham_pkg;

  localparam int DEF_COORD_W = 8;
  localparam int DEF_ERR_W   = DEF_COORD_W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PLOT  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  typedef logic signed [DEF_ERR_W-1:0] err_t;

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham iteration: given the current point and error term, produce
// the next point and error. Both axis updates may fire in the same step and
// are decided from the same doubled error value.
module bresenham_step
  import bresenham_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic                      [COORD_W-1:0] i_x,
  input  logic                      [COORD_W-1:0] i_y,
  input  logic signed [COORD_W+2:0]               i_err,
  input  logic signed [COORD_W+2:0]               i_dx,
  input  logic signed [COORD_W+2:0]               i_dy,
  input  logic                                    i_sxNeg,
  input  logic                                    i_syNeg,
  output logic                      [COORD_W-1:0] o_xNext,
  output logic                      [COORD_W-1:0] o_yNext,
  output logic signed [COORD_W+2:0]               o_errNext
);

  localparam int ERR_W = COORD_W + 3;

  logic signed [ERR_W:0]   w_e2;
  logic signed [ERR_W:0]   w_dxExt;
  logic signed [ERR_W:0]   w_dyExt;
  logic                    w_stepX;
  logic                    w_stepY;
  logic signed [ERR_W-1:0] w_addX;
  logic signed [ERR_W-1:0] w_addY;

  // Doubled error and deltas widened by one bit so the compare cannot overflow
  always_comb begin
    w_e2    = {i_err, 1'b0};
    w_dxExt = {i_dx[ERR_W-1], i_dx};
    w_dyExt = {i_dy[ERR_W-1], i_dy};
    w_stepX = (w_e2 >= w_dyExt);
    w_stepY = (w_e2 <= w_dxExt);
  end

  // Accumulate both error contributions and move along each axis that stepped
  always_comb begin
    w_addX    = w_stepX ? i_dy : '0;
    w_addY    = w_stepY ? i_dx : '0;
    o_errNext = i_err + w_addX + w_addY;
    o_xNext   = i_x;
    o_yNext   = i_y;
    if (w_stepX) begin
      o_xNext = i_sxNeg ? (i_x - COORD_W'(1)) : (i_x + COORD_W'(1));
    end
    if (w_stepY) begin
      o_yNext = i_syNeg ? (i_y - COORD_W'(1)) : (i_y + COORD_W'(1));
    end
  end

endmodule

// File: rtl/bresenham_line_engine.sv
// Rasterizes one line segment per draw_en request, emitting one pixel per
// accepted valid/ready cycle and pulsing draw_done after the last pixel.
// Optional build macro BRESENHAM_ABORT_EN: when defined, dropping draw_en in
// SETUP or PLOT abandons the line and returns to IDLE without draw_done.
module bresenham_line_engine
  import bresenham_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               draw_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               draw_done,
  output logic               busy
);

  localparam int ERR_W = COORD_W + 3;

  state_e                  r_state;
  state_e                  w_nextState;
  logic [COORD_W-1:0]      r_x;
  logic [COORD_W-1:0]      r_y;
  logic [COORD_W-1:0]      r_x1;
  logic [COORD_W-1:0]      r_y1;
  logic signed [ERR_W-1:0] r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sxNeg;
  logic                    r_syNeg;

  logic signed [ERR_W-1:0] w_x0Ext;
  logic signed [ERR_W-1:0] w_y0Ext;
  logic signed [ERR_W-1:0] w_x1Ext;
  logic signed [ERR_W-1:0] w_y1Ext;
  logic signed [ERR_W-1:0] w_dxInit;
  logic signed [ERR_W-1:0] w_dyInit;
  logic [COORD_W-1:0]      w_xNext;
  logic [COORD_W-1:0]      w_yNext;
  logic signed [ERR_W-1:0] w_errNext;
  logic                    w_atEnd;
  logic                    w_accept;

  assign w_x0Ext  = ERR_W'(x0);
  assign w_y0Ext  = ERR_W'(y0);
  assign w_x1Ext  = ERR_W'(x1);
  assign w_y1Ext  = ERR_W'(y1);
  assign w_dxInit = (x0 < x1) ? (w_x1Ext - w_x0Ext) : (w_x0Ext - w_x1Ext);
  assign w_dyInit = (y0 < y1) ? (w_y0Ext - w_y1Ext) : (w_y1Ext - w_y0Ext);
  assign w_atEnd  = (r_x == r_x1) && (r_y == r_y1);
  assign w_accept = (r_state == PLOT) && pix_ready;

  bresenham_step #(
    .COORD_W (COORD_W)
  ) u_step (
    .i_x       (r_x),
    .i_y       (r_y),
    .i_err     (r_err),
    .i_dx      (r_dx),
    .i_dy      (r_dy),
    .i_sxNeg   (r_sxNeg),
    .i_syNeg   (r_syNeg),
    .o_xNext   (w_xNext),
    .o_yNext   (w_yNext),
    .o_errNext (w_errNext)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; HOLD blocks re-triggering until the request is withdrawn
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (draw_en) w_nextState = SETUP;
`ifdef BRESENHAM_ABORT_EN
      SETUP: w_nextState = draw_en ? PLOT : IDLE;
      PLOT: begin
        if (!draw_en)                 w_nextState = IDLE;
        else if (pix_ready && w_atEnd) w_nextState = DONE;
      end
`else
      SETUP: w_nextState = PLOT;
      PLOT:  if (pix_ready && w_atEnd) w_nextState = DONE;
`endif
      DONE:  w_nextState = HOLD;
      HOLD:  if (!draw_en) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from state only, zeroed outside PLOT
  always_comb begin
    pix_valid = (r_state == PLOT);
    pix_x     = (r_state == PLOT) ? r_x : '0;
    pix_y     = (r_state == PLOT) ? r_y : '0;
    draw_done = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Datapath: latch the segment in SETUP, advance one step per accepted pixel
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_sxNeg <= 1'b0;
      r_syNeg <= 1'b0;
    end else if (r_state == SETUP) begin
      r_x     <= x0;
      r_y     <= y0;
      r_x1    <= x1;
      r_y1    <= y1;
      r_dx    <= w_dxInit;
      r_dy    <= w_dyInit;
      r_err   <= w_dxInit + w_dyInit;
      r_sxNeg <= !(x0 < x1);
      r_syNeg <= !(y0 < y1);
    end else if (w_accept && !w_atEnd) begin
      r_x     <= w_xNext;
      r_y     <= w_yNext;
      r_err   <= w_errNext;
    end
  end

endmodule
